// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round sequencing logic.
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam int NUM_ROUNDS_DEFAULT = 64;
    localparam int MSG_DIRECT_WORDS   = 16;

endpackage

// File: rtl/round_counter.sv
// Rollover round counter: counts 0..MAX-1 while enabled, then wraps to 0.
module round_counter #(
    parameter int MAX = 64,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == W'(MAX - 1)) ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: LOAD, NUM_ROUNDS rounds, FINAL add, DONE handshake.
// Define SHA256_DOUBLE_HASH_EN to run a second pass over the first digest.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
    parameter int RND_BITS   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                start_ready,
    input  logic                abort,
    output logic                load_iv,
    output logic                round_en,
    output logic [RND_BITS-1:0] round_idx,
    output logic                w_sel,
    output logic                add_final,
    output logic                pass_num,
    output logic                hash_valid,
    input  logic                hash_ack,
    output logic                busy
);

    state_t state_q, state_d;
    logic   last_round;
    logic   cnt_clr;

`ifdef SHA256_DOUBLE_HASH_EN
    logic pass_q, pass_d;
`endif

    assign cnt_clr    = abort || (state_q == S_IDLE) || (state_q == S_LOAD);
    assign last_round = (round_idx == RND_BITS'(NUM_ROUNDS - 1));

    round_counter #(
        .MAX (NUM_ROUNDS),
        .W   (RND_BITS)
    ) u_round_counter (
        .clk (clk),
        .rst (rst),
        .en  (state_q == S_ROUND),
        .clr (cnt_clr),
        .cnt (round_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
`ifdef SHA256_DOUBLE_HASH_EN
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef SHA256_DOUBLE_HASH_EN
            pass_q  <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef SHA256_DOUBLE_HASH_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
`ifdef SHA256_DOUBLE_HASH_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: if (last_round) state_d = S_FINAL;
            S_FINAL: begin
`ifdef SHA256_DOUBLE_HASH_EN
                if (!pass_q) begin
                    state_d = S_LOAD;
                    pass_d  = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                // ack together with start chains straight into the next block
                if (hash_ack) begin
                    state_d = start ? S_LOAD : S_IDLE;
`ifdef SHA256_DOUBLE_HASH_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
`ifdef SHA256_DOUBLE_HASH_EN
            pass_d  = 1'b0;
`endif
        end
    end

    assign start_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && hash_ack);
    assign load_iv     = (state_q == S_LOAD);
    assign round_en    = (state_q == S_ROUND);
    assign w_sel       = (state_q == S_ROUND) && (round_idx >= RND_BITS'(MSG_DIRECT_WORDS));
    assign add_final   = (state_q == S_FINAL);
    assign hash_valid  = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);

`ifdef SHA256_DOUBLE_HASH_EN
    assign pass_num = pass_q;
`else
    assign pass_num = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl; honours SHA256_DOUBLE_HASH_EN when defined.
module tb_sha256_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start_ready;
    logic       abort;
    logic       load_iv;
    logic       round_en;
    logic [5:0] round_idx;
    logic       w_sel;
    logic       add_final;
    logic       pass_num;
    logic       hash_valid;
    logic       hash_ack;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl #(
        .NUM_ROUNDS (64),
        .RND_BITS   (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_ready (start_ready),
        .abort       (abort),
        .load_iv     (load_iv),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .w_sel       (w_sel),
        .add_final   (add_final),
        .pass_num    (pass_num),
        .hash_valid  (hash_valid),
        .hash_ack    (hash_ack),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered at the negedge of a LOAD cycle; leaves at the negedge of the FINAL cycle,
    // or one cycle after abort if abort_at hits.
    task automatic do_pass(input logic p, input int abort_at, input int start_at,
                           output bit aborted);
        aborted = 1'b0;
        check("load_iv", load_iv, 1);
        check("load_pass", pass_num, p);
        check("load_rnd_en", round_en, 0);
        for (int r = 0; r < 64; r++) begin
            @(negedge clk);
            start = 1'b0;
            check("round_en", round_en, 1);
            check("round_idx", round_idx, r);
            check("w_sel", w_sel, (r >= 16) ? 1 : 0);
            check("rnd_load_iv", load_iv, 0);
            check("rnd_add_final", add_final, 0);
            if (r == start_at) begin
                start = 1'b1;
                #1 check("rnd_start_ready", start_ready, 0);
            end
            if (r == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_idx", round_idx, 0);
                check("abort_rnd_en", round_en, 0);
                check("abort_add_final", add_final, 0);
                check("abort_ready", start_ready, 1);
                aborted = 1'b1;
                return;
            end
        end
        @(negedge clk);
        check("add_final", add_final, 1);
        check("final_rnd_en", round_en, 0);
        check("final_pass", pass_num, p);
    endtask

    // Start pulse already set up by caller at a negedge; runs through to first DONE cycle.
    task automatic run_block(input int abort_at, input int start_at, output bit aborted);
        @(negedge clk);
        start = 1'b0;
        do_pass(1'b0, abort_at, start_at, aborted);
        if (aborted) return;
`ifdef SHA256_DOUBLE_HASH_EN
        @(negedge clk);
        do_pass(1'b1, -1, -1, aborted);
`endif
        @(negedge clk);
        check("hash_valid", hash_valid, 1);
        check("done_busy", busy, 1);
        check("done_idx", round_idx, 0);
        check("done_ready", start_ready, 0);
    endtask

    task automatic ack_to_idle();
        hash_ack = 1'b1;
        #1 check("ack_ready", start_ready, 1);
        @(negedge clk);
        hash_ack = 1'b0;
        check("idle_valid", hash_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_ready", start_ready, 1);
    endtask

    initial begin
        bit ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0; hash_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", start_ready, 1);
        check("rst_idx", round_idx, 0);
        check("rst_pass", pass_num, 0);
        check("rst_busy", busy, 0);
        check("rst_load", load_iv, 0);
        check("rst_rnd_en", round_en, 0);
        check("rst_valid", hash_valid, 0);
        check("rst_add", add_final, 0);
        rst = 1'b0;
        @(negedge clk);

        // basic pass, then hold DONE without ack
        start = 1'b1;
        run_block(-1, -1, ab);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", hash_valid, 1);
            check("hold_idx", round_idx, 0);
        end
        ack_to_idle();

        // back-to-back: ack and start in the same cycle
        start = 1'b1;
        run_block(-1, -1, ab);
        hash_ack = 1'b1;
        start = 1'b1;
        #1 check("b2b_ready", start_ready, 1);
        @(negedge clk);
        hash_ack = 1'b0;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        do_pass(1'b0, -1, -1, ab);
`ifdef SHA256_DOUBLE_HASH_EN
        @(negedge clk);
        do_pass(1'b1, -1, -1, ab);
`endif
        @(negedge clk);
        check("b2b_valid", hash_valid, 1);
        ack_to_idle();

        // abort at round 30, then a fresh start
        start = 1'b1;
        run_block(30, -1, ab);
        check("abort_seen", ab, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_add", add_final, 0);
            check("post_abort_valid", hash_valid, 0);
        end
        start = 1'b1;
        run_block(-1, -1, ab);
        ack_to_idle();

        // start during ROUND is ignored
        start = 1'b1;
        run_block(-1, 40, ab);
        ack_to_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_extra_load", load_iv, 0);
            check("no_extra_busy", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
